// File: rtl/shift_rows_col_buffer.sv
// Column buffer feeding the column mixer: collects four state columns, then
// emits them with the row rotation applied (row r taken from column idx+r).
module shift_rows_col_buffer #(
   parameter int d = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [3:0][d+7:0]    in_col,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [3:0][d+7:0]    out_col,
   output logic                 out_last
);

   // state   | meaning
   // S_FILL  | accepting columns 0..3 into r_buf[fill_idx]
   // S_DRAIN | emitting rotated columns 0..3 from r_buf

   localparam int W = 8 + d;

   typedef logic [3:0][W-1:0] state_word_t;
   typedef enum logic {S_FILL, S_DRAIN} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [1:0]         r_fill_idx;
   logic [1:0]         w_fill_nxt;
   logic [1:0]         r_drain_idx;
   logic [1:0]         w_drain_nxt;
   state_word_t [3:0]  r_buf;
   state_word_t        w_shift;
   logic               w_in_hs;
   logic               w_out_hs;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_FILL;
         r_fill_idx  <= 2'd0;
         r_drain_idx <= 2'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_fill_idx  <= w_fill_nxt;
         r_drain_idx <= w_drain_nxt;
      end
   end

   // rst_n gates the handshakes so nothing is offered while reset is held
   always_comb begin
      in_ready    = rst_n & ~flush & (r_state == S_FILL);
      out_valid   = rst_n & ~flush & (r_state == S_DRAIN);
      w_in_hs     = in_valid & in_ready;
      w_out_hs    = out_valid & out_ready;
      w_state_nxt = r_state;
      w_fill_nxt  = r_fill_idx;
      w_drain_nxt = r_drain_idx;
      if (flush) begin
         w_state_nxt = S_FILL;
         w_fill_nxt  = 2'd0;
         w_drain_nxt = 2'd0;
      end else begin
         case (r_state)
            S_FILL: begin
               if (w_in_hs) begin
                  w_fill_nxt = r_fill_idx + 2'd1;
                  if (r_fill_idx == 2'd3) w_state_nxt = S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (w_out_hs) begin
                  w_drain_nxt = r_drain_idx + 2'd1;
                  if (r_drain_idx == 2'd3) w_state_nxt = S_FILL;
               end
            end
            default: w_state_nxt = S_FILL;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf <= '0;
      end else if (flush) begin
         r_buf <= '0;
      end else if (w_in_hs) begin
         r_buf[r_fill_idx] <= in_col;
      end
   end

   // 2-bit index addition wraps, giving the mod-4 column selection for free
   always_comb begin
      w_shift = '0;
      for (int r = 0; r < 4; r++) begin
         w_shift[r] = r_buf[r_drain_idx + 2'(r)][r];
      end
   end

   assign out_col  = out_valid ? w_shift : '0;
   assign out_last = out_valid & (r_drain_idx == 2'd3);

endmodule

// File: tb/tb_shift_rows_col_buffer.sv
// Scoreboard bench: a reference model collects accepted columns, computes the
// rotated output columns arithmetically, and a negedge monitor compares them.
module tb_shift_rows_col_buffer;

   localparam int W = 10;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              flush = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [3:0][W-1:0] in_col = '0;
   logic              out_valid;
   logic              out_ready;
   logic [3:0][W-1:0] out_col;
   logic              out_last;

   shift_rows_col_buffer #(.d(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_col    (in_col),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_col   (out_col),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int hs_in  = 0;
   int hs_out = 0;
   bit rnd_ready = 1'b0;
   logic ready_val = 1'b1;

   typedef struct {
      logic [3:0][W-1:0] col;
      bit                last;
   } exp_t;

   exp_t              q[$];
   logic [3:0][W-1:0] m_cols[4];
   int                m_nin = 0;
   bit                m_drain = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_nin   = 0;
      m_drain = 1'b0;
      q.delete();
   endtask

   // output column c, row r comes from input column (c+r) mod 4, row r
   task automatic model_push_state();
      exp_t e;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) e.col[r] = m_cols[(c + r) % 4][r];
         e.last = (c == 3);
         q.push_back(e);
      end
   endtask

   // downstream ready: either a held value or a coin flip each cycle
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_val;
      end
   end

   initial begin
      exp_t e;
      bit   exp_ir, exp_ov;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_out_col", out_col, 0);
            model_clear();
         end else begin
            exp_ir = !flush && !m_drain;
            exp_ov = !flush && m_drain;
            chk("in_ready", in_ready, exp_ir);
            chk("out_valid", out_valid, exp_ov);
            if (exp_ov) begin
               if (q.size() == 0) begin
                  errors++;
                  $display("FAIL scoreboard_empty: got draining expected queued data at %0t", $time);
               end else begin
                  chk("out_col", out_col, q[0].col);
                  chk("out_last", out_last, q[0].last);
               end
            end else begin
               chk("idle_out_col", out_col, 0);
               chk("idle_out_last", out_last, 0);
            end
            if (flush) begin
               model_clear();
            end else if (exp_ov && out_ready) begin
               if (q.size() != 0) begin
                  e = q.pop_front();
                  hs_out++;
                  if (e.last) m_drain = 1'b0;
               end
            end else if (exp_ir && in_valid) begin
               m_cols[m_nin] = in_col;
               m_nin++;
               hs_in++;
               if (m_nin == 4) begin
                  model_push_state();
                  m_nin   = 0;
                  m_drain = 1'b1;
               end
            end
         end
      end
   end

   function automatic logic [3:0][W-1:0] fixed_col(input int c);
      logic [3:0][W-1:0] v;
      for (int r = 0; r < 4; r++) v[r] = W'(c * 16 + r);
      return v;
   endfunction

   function automatic logic [3:0][W-1:0] rand_col();
      logic [3:0][W-1:0] v;
      for (int r = 0; r < 4; r++) v[r] = W'($urandom);
      return v;
   endfunction

   task automatic send(input logic [3:0][W-1:0] col);
      in_col   = col;
      in_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            return;
         end
      end
      in_valid = 1'b0;
      errors++;
      checks++;
      $display("FAIL send_timeout: got no in_ready expected accept at %0t", $time);
   endtask

   task automatic wait_drained();
      for (int i = 0; i < 500; i++) begin
         @(posedge clk);
         #1;
         if (!m_drain && q.size() == 0) return;
      end
      errors++;
      checks++;
      $display("FAIL drain_timeout: got %0d pending expected 0 at %0t", q.size(), $time);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("in_ready_after_release", in_ready, 1);

      // known pattern, free-flowing downstream
      ready_val = 1'b1;
      for (int c = 0; c < 4; c++) send(fixed_col(c));
      wait_drained();

      // same pattern, downstream stalls 5 cycles at drain entry
      for (int c = 0; c < 4; c++) send(fixed_col(c));
      ready_val = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      ready_val = 1'b1;
      wait_drained();

      // two states streamed back to back
      hs_in  = 0;
      hs_out = 0;
      in_valid = 1'b1;
      for (int k = 0; k < 16; k++) begin
         in_col = rand_col();
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      chk("stream_in_handshakes", hs_in, 8);
      chk("stream_out_handshakes", hs_out, 8);
      wait_drained();

      // flush after two accepted columns
      send(rand_col());
      send(rand_col());
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      for (int c = 0; c < 4; c++) send(rand_col());
      wait_drained();

      // flush coincident with the fourth input
      for (int c = 0; c < 3; c++) send(rand_col());
      in_col   = rand_col();
      in_valid = 1'b1;
      flush    = 1'b1;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("flush_4th_out_valid", out_valid, 0);
      for (int c = 0; c < 4; c++) send(fixed_col(c + 4));
      wait_drained();

      // reset mid-drain after one output
      for (int c = 0; c < 4; c++) send(rand_col());
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_drain_out_valid", out_valid, 0);
      chk("rst_mid_drain_in_ready", in_ready, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("rst_release_in_ready", in_ready, 1);
      for (int c = 0; c < 4; c++) send(rand_col());
      wait_drained();

      // random traffic with occasional flushes in either phase
      rnd_ready = 1'b1;
      for (int s = 0; s < 25; s++) begin
         int fl_at;
         fl_at = $urandom_range(0, 9);
         for (int c = 0; c < 4; c++) begin
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1;
            end
            if (fl_at == c) begin
               flush = 1'b1;
               @(posedge clk);
               #1;
               flush = 1'b0;
            end
            send(rand_col());
         end
         if (fl_at == 4) begin
            repeat ($urandom_range(0, 3)) begin
               @(posedge clk);
               #1;
            end
            flush = 1'b1;
            @(posedge clk);
            #1;
            flush = 1'b0;
         end
         wait_drained();
      end
      rnd_ready = 1'b0;
      repeat (3) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
